i2s_tdm_tx_fifo: RTL

Parametrised successor I2S/TDM serialiser for the audio output path. It takes multichannel sample frames through a valid/ready handshake into an internal frame FIFO. It derives BCK and WS from the master audio clock and serialises 2 channels (I2S/left-justified stereo) or 4/6/8 channels (TDM), MSB first. Underflow is detected and flagged, and output is muted on underflow.

---
 rtl/i2s_tdm_tx_fifo.sv | 125 ++++++++++++
 1 files changed

// File: rtl/i2s_tdm_tx_fifo.sv
// I2S / TDM transmitter with an internal frame FIFO. BCK and WS are derived from AMCLK_i, and
// serial data is sent MSB first. An empty FIFO at frame start mutes the frame and sets a sticky flag.
module i2s_tdm_tx_fifo #(
  parameter int unsigned DATA_BITS    = 24,
  parameter int unsigned NUM_CH       = 2,
  parameter int unsigned SLOT_BITS    = 32,
  parameter int unsigned MCLK_PER_BCK = 4,
  parameter int unsigned FIFO_DEPTH   = 8
) (
  input  logic                          AMCLK_i,
  input  logic                          reset_n,
  input  logic                          enable_i,
  input  logic                          fmt_lj_i,
  input  logic [NUM_CH*DATA_BITS-1:0]   in_data_i,
  input  logic                          in_valid_i,
  output logic                          in_ready_o,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_level_o,
  output logic                          underflow_o,
  input  logic                          clr_underflow_i,
  output logic                          I2S_BCK,
  output logic                          I2S_WS,
  output logic                          I2S_DATA
);

  localparam int unsigned FrameW    = NUM_CH * DATA_BITS;
  localparam int unsigned AddrW     = $clog2(FIFO_DEPTH);
  localparam int unsigned PtrW      = AddrW + 1;
  localparam int unsigned MclkW     = $clog2(MCLK_PER_BCK);
  localparam int unsigned FrameBcks = NUM_CH * SLOT_BITS;
  localparam int unsigned BitW      = $clog2(FrameBcks);
  localparam int unsigned IdxW      = $clog2(FrameW);

  logic [FrameW-1:0] mem_q [FIFO_DEPTH];
  logic [PtrW-1:0]   wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d, level_q, level_d;
  logic [MclkW-1:0]  mclk_ctr_q, mclk_ctr_d;
  logic [BitW-1:0]   bit_ctr_q, bit_ctr_d;
  logic [FrameW-1:0] frame_q, frame_d;
  logic              underflow_q, underflow_d;
  logic              bck_q, bck_d, ws_q, ws_d, data_q, data_d;
  logic              wr_en, frame_start, pop;
  int unsigned       slot_pos, slot_ch, bit_sel;
  logic              in_word;
  logic [IdxW-1:0]   bit_idx;

  assign in_ready_o   = (level_q != PtrW'(FIFO_DEPTH));
  assign fifo_level_o = level_q;
  assign underflow_o  = underflow_q;
  assign I2S_BCK      = bck_q;
  assign I2S_WS       = ws_q;
  assign I2S_DATA     = data_q;

  always_comb begin
    wr_en       = in_valid_i && in_ready_o;
    frame_start = enable_i && (bit_ctr_q == '0) && (mclk_ctr_q == '0);
    // Pop decision looks only at the registered level; a same-cycle write cannot rescue it.
    pop         = frame_start && (level_q != '0);
    wr_ptr_d    = wr_ptr_q + PtrW'(wr_en);
    rd_ptr_d    = rd_ptr_q + PtrW'(pop);
    level_d     = level_q + PtrW'(wr_en) - PtrW'(pop);
    underflow_d = (frame_start && !pop) ? 1'b1 : (clr_underflow_i ? 1'b0 : underflow_q);
    mclk_ctr_d  = '0;
    bit_ctr_d   = '0;
    frame_d     = '0;
    if (enable_i) begin
      mclk_ctr_d = mclk_ctr_q + 1'b1;
      bit_ctr_d  = bit_ctr_q;
      if (mclk_ctr_q == MclkW'(MCLK_PER_BCK - 1)) begin
        mclk_ctr_d = '0;
        bit_ctr_d  = (bit_ctr_q == BitW'(FrameBcks - 1)) ? '0 : bit_ctr_q + 1'b1;
      end
      frame_d = frame_q;
      if (frame_start) frame_d = pop ? mem_q[rd_ptr_q[AddrW-1:0]] : '0;
    end
  end

  // Outputs use frame_d so the first bit of a freshly popped frame is not stale.
  always_comb begin
    slot_pos = 32'(bit_ctr_q) % SLOT_BITS;
    slot_ch  = 32'(bit_ctr_q) / SLOT_BITS;
    if (fmt_lj_i) begin
      in_word = (slot_pos < DATA_BITS);
      bit_sel = DATA_BITS - 1 - slot_pos;
    end else begin
      in_word = (slot_pos >= 1) && (slot_pos <= DATA_BITS);
      bit_sel = DATA_BITS - slot_pos;
    end
    bit_idx = in_word ? IdxW'(slot_ch * DATA_BITS + bit_sel) : '0;
    bck_d   = enable_i && (mclk_ctr_q >= MclkW'(MCLK_PER_BCK / 2));
    data_d  = enable_i && in_word && frame_d[bit_idx];
    if (NUM_CH == 2)   ws_d = enable_i && (slot_ch == 1);
    else if (fmt_lj_i) ws_d = enable_i && (bit_ctr_q == '0);
    else               ws_d = enable_i && (bit_ctr_q == BitW'(FrameBcks - 1));
  end

  always_ff @(posedge AMCLK_i or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      level_q     <= '0;
      mclk_ctr_q  <= '0;
      bit_ctr_q   <= '0;
      frame_q     <= '0;
      underflow_q <= 1'b0;
      bck_q       <= 1'b0;
      ws_q        <= 1'b0;
      data_q      <= 1'b0;
    end else begin
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      level_q     <= level_d;
      mclk_ctr_q  <= mclk_ctr_d;
      bit_ctr_q   <= bit_ctr_d;
      frame_q     <= frame_d;
      underflow_q <= underflow_d;
      bck_q       <= bck_d;
      ws_q        <= ws_d;
      data_q      <= data_d;
    end
  end

  always_ff @(posedge AMCLK_i) begin
    if (wr_en) mem_q[wr_ptr_q[AddrW-1:0]] <= in_data_i;
  end

endmodule
